axi4_slave_mem: RTL and testbench
=================================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DEPTH, default 256, memory size in 32-bit words; power of 2, at least 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have AW-channel ports:
- S_AXI_AWADDR_i, input, ADDR_W
- S_AXI_AWLEN_i, input, 8
- S_AXI_AWSIZE_i, input, 3
- S_AXI_AWBURST_i, input, 2
- S_AXI_AWVALID_i, input, 1
- S_AXI_AWREADY_o, output, 1
REQ-006 SHALL have W-channel ports:
- S_AXI_WDATA_i, input, 32
- S_AXI_WSTRB_i, input, 4
- S_AXI_WLAST_i, input, 1
- S_AXI_WVALID_i, input, 1
- S_AXI_WREADY_o, output, 1
REQ-007 SHALL have B-channel ports:
- S_AXI_BRESP_o, output, 2
- S_AXI_BVALID_o, output, 1
- S_AXI_BREADY_i, input, 1
REQ-008 SHALL have AR-channel ports named as AW with the AR prefix (S_AXI_ARADDR_i ... S_AXI_ARREADY_o), same widths and directions.
REQ-009 SHALL have R-channel ports:
- S_AXI_RDATA_o, output, 32
- S_AXI_RRESP_o, output, 2
- S_AXI_RLAST_o, output, 1
- S_AXI_RVALID_o, output, 1
- S_AXI_RREADY_i, input, 1

Function
REQ-010 SHALL implement the AXI4 responder end: word memory mem[DEPTH]; word index = addr[log2(DEPTH)+1:2].
REQ-011 SHALL run independent write and read FSMs; both may be active in the same cycle.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP:
- W_IDLE: AWREADY=1; AW handshake latches addr/len/size/burst, goes to W_DATA.
- W_DATA: WREADY=1; each W handshake writes bytes enabled by WSTRB.
- Beat len+1 goes to W_RESP.
- W_RESP: BVALID=1, held stable until BREADY; then goes to W_IDLE.
REQ-013 BVALID SHALL assert in the cycle after the final W handshake.
REQ-014 A burst with WLAST mismatch SHALL still complete its beats and return BRESP=SLVERR:
- WLAST=0 on beat len+1, or
- WLAST=1 on any earlier beat.
REQ-015 Read FSM SHALL have states R_IDLE and R_DATA:
- R_IDLE: ARREADY=1; AR handshake goes to R_DATA.
- RVALID SHALL first assert the cycle after the AR handshake.
- RDATA/RRESP/RLAST SHALL be held stable while RVALID=1 and RREADY=0.
- RLAST=1 only on beat len+1; that beat's handshake returns to R_IDLE.
REQ-016 Address sequencing SHALL be:
- FIXED (00): address constant.
- INCR (01): address +4 per beat.
- WRAP (10): address +4, wrapping within an aligned (len+1)*4-byte window.
REQ-017 The following SHALL be illegal bursts: burst=11, SIZE other than 2, WRAP with len not in {1,3,7,15}, or INCR crossing a 4 KB boundary. An illegal burst SHALL:
- complete all beats;
- suppress memory writes;
- return SLVERR, with RDATA=0 on reads.
REQ-018 When the same word is written and read in the same cycle, the read SHALL return the old data.
REQ-019 RRESP SHALL be OKAY (00) for legal beats.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- both FSMs to IDLE;
- AWREADY=0, ARREADY=0, WREADY=0, BVALID=0, RVALID=0, RLAST=0;
- BRESP=00, RRESP=00, RDATA=0.
REQ-021 AWREADY and ARREADY SHALL assert in the first cycle after rst_n deasserts.
REQ-022 Reset during a burst SHALL abandon it without a response; memory contents are undefined after reset.

Configuration
REQ-023 Macro AXI4_SLAVE_MEM_RANGE_CHECK_EN SHALL control address range checking:
- Defined: any beat address >= DEPTH*4 returns SLVERR, suppresses its write, and returns RDATA=0.
- Undefined: upper address bits are ignored and the address aliases modulo DEPTH*4 with OKAY.

Structure
REQ-024 Shared package axi4_pkg SHALL hold:
- burst enum (FIXED, INCR, WRAP, RSVD);
- resp constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11);
- FSM state typedefs.
REQ-025 Sub-module axi4_burst_addr_gen SHALL compute the next address and the legality flag; the write and read paths SHALL each instantiate it once.

Verification
REQ-026 INCR write AWADDR=0x10, LEN=3, data 1..4, WSTRB=F -> BRESP=00 one cycle after the 4th beat; INCR read of the same range returns 1,2,3,4 with RLAST on beat 4.
REQ-027 WRAP read ARADDR=0x1C, LEN=3 -> beat addresses 0x1C, 0x10, 0x14, 0x18.
REQ-028 Write with WSTRB=0x3, data 0xAABBCCDD over 0x11223344 -> readback 0x1122CCDD.
REQ-029 RREADY held low 5 cycles -> RDATA/RLAST stable; AWBURST=11 -> no memory change, BRESP=10.
REQ-030 Write with WLAST early on beat 2 of LEN=3 -> BRESP=10; rst_n pulse mid-read -> RVALID=0 immediately and ARREADY=1 the cycle after release.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 types for the slave memory: burst encodings, response codes and FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address and burst legality for one AXI4 channel (FIXED/INCR/WRAP, 32-bit beats only).
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              legal
);

  logic [8:0]        len_p1_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic [ADDR_W-1:0] incr_addr_s;
  logic [12:0]       incr_end_s;
  logic              wrap_len_ok_s;

  assign len_p1_s    = {1'b0, len} + 9'd1;
  assign wrap_mask_s = (ADDR_W'(len_p1_s) << 2) - ADDR_W'(1);
  assign incr_addr_s = addr + ADDR_W'(4);
  // Byte just past the burst, relative to the 4 KB page; beyond 0x1000 means a page crossing.
  assign incr_end_s  = {1'b0, addr[11:2], 2'b00} + {2'b00, len_p1_s, 2'b00};

  // Only power-of-two wrap lengths of 2..16 beats are legal.
  always_comb begin
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok_s = 1'b1;
      default:                 wrap_len_ok_s = 1'b0;
    endcase
  end

  // Address step: constant, linear, or wrapped inside the aligned burst window.
  always_comb begin
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_addr_s;
      WRAP:    next_addr = (addr & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
      default: next_addr = addr;
    endcase
  end

  // Legality of the whole burst, judged from its start address.
  always_comb begin
    if (size != SIZE_WORD) begin
      legal = 1'b0;
    end else begin
      case (burst)
        FIXED:   legal = 1'b1;
        INCR:    legal = (incr_end_s <= 13'h1000);
        WRAP:    legal = wrap_len_ok_s;
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave word memory with independent write/read burst engines.
// Optional macro AXI4_SLAVE_MEM_RANGE_CHECK_EN rejects beats beyond DEPTH*4 instead of aliasing.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR_i,
  input  logic [7:0]        S_AXI_AWLEN_i,
  input  logic [2:0]        S_AXI_AWSIZE_i,
  input  logic [1:0]        S_AXI_AWBURST_i,
  input  logic              S_AXI_AWVALID_i,
  output logic              S_AXI_AWREADY_o,
  input  logic [31:0]       S_AXI_WDATA_i,
  input  logic [3:0]        S_AXI_WSTRB_i,
  input  logic              S_AXI_WLAST_i,
  input  logic              S_AXI_WVALID_i,
  output logic              S_AXI_WREADY_o,
  output logic [1:0]        S_AXI_BRESP_o,
  output logic              S_AXI_BVALID_o,
  input  logic              S_AXI_BREADY_i,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR_i,
  input  logic [7:0]        S_AXI_ARLEN_i,
  input  logic [2:0]        S_AXI_ARSIZE_i,
  input  logic [1:0]        S_AXI_ARBURST_i,
  input  logic              S_AXI_ARVALID_i,
  output logic              S_AXI_ARREADY_o,
  output logic [31:0]       S_AXI_RDATA_o,
  output logic [1:0]        S_AXI_RRESP_o,
  output logic              S_AXI_RLAST_o,
  output logic              S_AXI_RVALID_o,
  input  logic              S_AXI_RREADY_i
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> 2);
  endfunction

  logic [31:0] mem_r [DEPTH];

  // Write-path state and its next-state values
  w_state_e          w_state_r, w_state_next_s;
  logic [ADDR_W-1:0] w_addr_r, w_addr_next_s;
  logic [7:0]        w_len_r, w_len_next_s, w_cnt_r, w_cnt_next_s;
  logic [2:0]        w_size_r, w_size_next_s;
  logic [1:0]        w_burst_r, w_burst_next_s;
  logic              w_legal_r, w_legal_next_s, w_err_r, w_err_next_s;
  logic              awready_r, awready_next_s, wready_r, wready_next_s;
  logic              bvalid_r, bvalid_next_s;
  logic [1:0]        bresp_r, bresp_next_s;
  logic              w_beat_err_s, mem_we_s, w_in_range_s;
  logic [ADDR_W-1:0] w_gen_addr_s, w_gen_next_s;
  logic [7:0]        w_gen_len_s;
  logic [2:0]        w_gen_size_s;
  logic [1:0]        w_gen_burst_s;
  logic              w_gen_legal_s;

  // Read-path state and its next-state values
  r_state_e          r_state_r, r_state_next_s;
  logic [ADDR_W-1:0] r_addr_r, r_addr_next_s;
  logic [7:0]        r_len_r, r_len_next_s, r_cnt_r, r_cnt_next_s;
  logic [2:0]        r_size_r, r_size_next_s;
  logic [1:0]        r_burst_r, r_burst_next_s;
  logic              r_legal_r, r_legal_next_s;
  logic              arready_r, arready_next_s, rvalid_r, rvalid_next_s;
  logic              rlast_r, rlast_next_s;
  logic [1:0]        rresp_r, rresp_next_s;
  logic [31:0]       rdata_r, rdata_next_s, rd_word_s;
  logic              r_in_range_s;
  logic [ADDR_W-1:0] r_load_addr_s, r_gen_addr_s, r_gen_next_s;
  logic [7:0]        r_gen_len_s;
  logic [2:0]        r_gen_size_s;
  logic [1:0]        r_gen_burst_s;
  logic              r_gen_legal_s;

  // While idle the generators judge the incoming request; afterwards they step the latched burst.
  assign w_gen_addr_s  = (w_state_r == W_IDLE) ? S_AXI_AWADDR_i  : w_addr_r;
  assign w_gen_len_s   = (w_state_r == W_IDLE) ? S_AXI_AWLEN_i   : w_len_r;
  assign w_gen_size_s  = (w_state_r == W_IDLE) ? S_AXI_AWSIZE_i  : w_size_r;
  assign w_gen_burst_s = (w_state_r == W_IDLE) ? S_AXI_AWBURST_i : w_burst_r;
  assign r_gen_addr_s  = (r_state_r == R_IDLE) ? S_AXI_ARADDR_i  : r_addr_r;
  assign r_gen_len_s   = (r_state_r == R_IDLE) ? S_AXI_ARLEN_i   : r_len_r;
  assign r_gen_size_s  = (r_state_r == R_IDLE) ? S_AXI_ARSIZE_i  : r_size_r;
  assign r_gen_burst_s = (r_state_r == R_IDLE) ? S_AXI_ARBURST_i : r_burst_r;

  axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_w_gen (
    .addr(w_gen_addr_s), .len(w_gen_len_s), .size(w_gen_size_s), .burst(w_gen_burst_s),
    .next_addr(w_gen_next_s), .legal(w_gen_legal_s)
  );

  axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_r_gen (
    .addr(r_gen_addr_s), .len(r_gen_len_s), .size(r_gen_size_s), .burst(r_gen_burst_s),
    .next_addr(r_gen_next_s), .legal(r_gen_legal_s)
  );

  // Address of the read beat being loaded into the R output register this cycle.
  assign r_load_addr_s = (r_state_r == R_IDLE) ? S_AXI_ARADDR_i : r_gen_next_s;
  assign rd_word_s     = mem_r[word_idx(r_load_addr_s)];

`ifdef AXI4_SLAVE_MEM_RANGE_CHECK_EN
  assign w_in_range_s = ((w_addr_r >> (IDX_W + 2)) == '0);
  assign r_in_range_s = ((r_load_addr_s >> (IDX_W + 2)) == '0);
`else
  assign w_in_range_s = 1'b1;
  assign r_in_range_s = 1'b1;
`endif

  // Write FSM next state, beat bookkeeping and response selection.
  always_comb begin
    w_state_next_s = w_state_r;
    w_addr_next_s  = w_addr_r;
    w_len_next_s   = w_len_r;
    w_size_next_s  = w_size_r;
    w_burst_next_s = w_burst_r;
    w_cnt_next_s   = w_cnt_r;
    w_legal_next_s = w_legal_r;
    w_err_next_s   = w_err_r;
    bresp_next_s   = bresp_r;
    w_beat_err_s   = 1'b0;
    mem_we_s       = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (S_AXI_AWVALID_i && awready_r) begin
          w_state_next_s = W_DATA;
          w_addr_next_s  = S_AXI_AWADDR_i;
          w_len_next_s   = S_AXI_AWLEN_i;
          w_size_next_s  = S_AXI_AWSIZE_i;
          w_burst_next_s = S_AXI_AWBURST_i;
          w_legal_next_s = w_gen_legal_s;
          w_cnt_next_s   = 8'd0;
          w_err_next_s   = 1'b0;
        end else begin
          w_state_next_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID_i && wready_r) begin
          w_beat_err_s = (S_AXI_WLAST_i != (w_cnt_r == w_len_r)) || !w_legal_r || !w_in_range_s;
          mem_we_s     = w_legal_r && w_in_range_s;
          if (w_cnt_r == w_len_r) begin
            w_state_next_s = W_RESP;
            bresp_next_s   = (w_err_r || w_beat_err_s) ? SLVERR : OKAY;
          end else begin
            w_addr_next_s = w_gen_next_s;
            w_cnt_next_s  = w_cnt_r + 8'd1;
            w_err_next_s  = w_err_r || w_beat_err_s;
          end
        end else begin
          w_state_next_s = W_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY_i && bvalid_r) begin
          w_state_next_s = W_IDLE;
        end else begin
          w_state_next_s = W_RESP;
        end
      end
      default: w_state_next_s = W_IDLE;
    endcase
    awready_next_s = (w_state_next_s == W_IDLE);
    wready_next_s  = (w_state_next_s == W_DATA);
    bvalid_next_s  = (w_state_next_s == W_RESP);
  end

  // Read FSM next state; the R register is reloaded only on AR accept or R handshake, so it holds under stall.
  always_comb begin
    r_state_next_s = r_state_r;
    r_addr_next_s  = r_addr_r;
    r_len_next_s   = r_len_r;
    r_size_next_s  = r_size_r;
    r_burst_next_s = r_burst_r;
    r_cnt_next_s   = r_cnt_r;
    r_legal_next_s = r_legal_r;
    rlast_next_s   = rlast_r;
    rresp_next_s   = rresp_r;
    rdata_next_s   = rdata_r;
    case (r_state_r)
      R_IDLE: begin
        if (S_AXI_ARVALID_i && arready_r) begin
          r_state_next_s = R_DATA;
          r_addr_next_s  = S_AXI_ARADDR_i;
          r_len_next_s   = S_AXI_ARLEN_i;
          r_size_next_s  = S_AXI_ARSIZE_i;
          r_burst_next_s = S_AXI_ARBURST_i;
          r_legal_next_s = r_gen_legal_s;
          r_cnt_next_s   = 8'd0;
          rlast_next_s   = (S_AXI_ARLEN_i == 8'd0);
          if (r_gen_legal_s && r_in_range_s) begin
            rdata_next_s = rd_word_s;
            rresp_next_s = OKAY;
          end else begin
            rdata_next_s = 32'd0;
            rresp_next_s = SLVERR;
          end
        end else begin
          r_state_next_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY_i && rvalid_r) begin
          if (rlast_r) begin
            r_state_next_s = R_IDLE;
            rlast_next_s   = 1'b0;
          end else begin
            r_addr_next_s = r_gen_next_s;
            r_cnt_next_s  = r_cnt_r + 8'd1;
            rlast_next_s  = ((r_cnt_r + 8'd1) == r_len_r);
            if (r_legal_r && r_in_range_s) begin
              rdata_next_s = rd_word_s;
              rresp_next_s = OKAY;
            end else begin
              rdata_next_s = 32'd0;
              rresp_next_s = SLVERR;
            end
          end
        end else begin
          r_state_next_s = R_DATA;
        end
      end
      default: r_state_next_s = R_IDLE;
    endcase
    arready_next_s = (r_state_next_s == R_IDLE);
    rvalid_next_s  = (r_state_next_s == R_DATA);
  end

  // Write-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_r <= W_IDLE;
      w_addr_r  <= '0;
      w_len_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
      w_cnt_r   <= 8'd0;
      w_legal_r <= 1'b0;
      w_err_r   <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= OKAY;
    end else begin
      w_state_r <= w_state_next_s;
      w_addr_r  <= w_addr_next_s;
      w_len_r   <= w_len_next_s;
      w_size_r  <= w_size_next_s;
      w_burst_r <= w_burst_next_s;
      w_cnt_r   <= w_cnt_next_s;
      w_legal_r <= w_legal_next_s;
      w_err_r   <= w_err_next_s;
      awready_r <= awready_next_s;
      wready_r  <= wready_next_s;
      bvalid_r  <= bvalid_next_s;
      bresp_r   <= bresp_next_s;
    end
  end

  // Read-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_r <= R_IDLE;
      r_addr_r  <= '0;
      r_len_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
      r_cnt_r   <= 8'd0;
      r_legal_r <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= OKAY;
      rdata_r   <= 32'd0;
    end else begin
      r_state_r <= r_state_next_s;
      r_addr_r  <= r_addr_next_s;
      r_len_r   <= r_len_next_s;
      r_size_r  <= r_size_next_s;
      r_burst_r <= r_burst_next_s;
      r_cnt_r   <= r_cnt_next_s;
      r_legal_r <= r_legal_next_s;
      arready_r <= arready_next_s;
      rvalid_r  <= rvalid_next_s;
      rlast_r   <= rlast_next_s;
      rresp_r   <= rresp_next_s;
      rdata_r   <= rdata_next_s;
    end
  end

  // Byte-masked memory write; contents are not reset, and a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB_i[b]) begin
          mem_r[word_idx(w_addr_r)][8*b +: 8] <= S_AXI_WDATA_i[8*b +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY_o = awready_r;
  assign S_AXI_WREADY_o  = wready_r;
  assign S_AXI_BVALID_o  = bvalid_r;
  assign S_AXI_BRESP_o   = bresp_r;
  assign S_AXI_ARREADY_o = arready_r;
  assign S_AXI_RVALID_o  = rvalid_r;
  assign S_AXI_RLAST_o   = rlast_r;
  assign S_AXI_RRESP_o   = rresp_r;
  assign S_AXI_RDATA_o   = rdata_r;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, wrap order, stalls, illegal bursts and reset.
module tb_axi4_slave_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  resp;

  axi4_slave_mem #(.ADDR_W(32), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR_i(awaddr), .S_AXI_AWLEN_i(awlen), .S_AXI_AWSIZE_i(awsize),
    .S_AXI_AWBURST_i(awburst), .S_AXI_AWVALID_i(awvalid), .S_AXI_AWREADY_o(awready),
    .S_AXI_WDATA_i(wdata), .S_AXI_WSTRB_i(wstrb), .S_AXI_WLAST_i(wlast),
    .S_AXI_WVALID_i(wvalid), .S_AXI_WREADY_o(wready),
    .S_AXI_BRESP_o(bresp), .S_AXI_BVALID_o(bvalid), .S_AXI_BREADY_i(bready),
    .S_AXI_ARADDR_i(araddr), .S_AXI_ARLEN_i(arlen), .S_AXI_ARSIZE_i(arsize),
    .S_AXI_ARBURST_i(arburst), .S_AXI_ARVALID_i(arvalid), .S_AXI_ARREADY_o(arready),
    .S_AXI_RDATA_o(rdata), .S_AXI_RRESP_o(rresp), .S_AXI_RLAST_o(rlast),
    .S_AXI_RVALID_o(rvalid), .S_AXI_RREADY_i(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write burst; beat index 'early' carries WLAST (-1 = WLAST only on the final beat).
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] strb, input int early,
                          output logic [1:0] bresp_o);
    int n;
    @(negedge clk);
    awaddr = addr; awlen = len[7:0]; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1'b1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wbuf[b]; wstrb = strb; wvalid = 1'b1;
      wlast = (early >= 0) ? (b == early) : (b == len);
      n = 0;
      while (wready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_next_cycle", bvalid, 1'b1);
    bresp_o = bresp;
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
  endtask

  // Full read burst; first beat is held 'stall' cycles with RREADY low and must stay exp_stall / RLAST=0.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int stall, input logic [31:0] exp_stall);
    int n;
    @(negedge clk);
    araddr = addr; arlen = len[7:0]; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1'b1);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_after_ar", rvalid, 1'b1);
    for (int s = 0; s < stall; s++) begin
      check("stall_rdata", rdata, exp_stall);
      check("stall_rlast", rlast, 1'b0);
      @(negedge clk);
    end
    rready = 1'b1;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast;
      @(posedge clk); @(negedge clk);
    end
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_arready", arready, 1'b1);

    // INCR write 0x10 of 1..4, read back
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(32'h10, 3, 2'b01, 3'd2, 4'hF, -1, resp);
    check("incr_bresp", resp, 2'b00);
    do_read(32'h10, 3, 2'b01, 3'd2, 0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rd_data[i], 32'(i + 1));
      check("incr_rlast", rd_last[i], (i == 3) ? 1'b1 : 1'b0);
      check("incr_rresp", rd_resp[i], 2'b00);
    end

    // WRAP read starting at 0x1C visits 0x1C, 0x10, 0x14, 0x18
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    do_write(32'h10, 3, 2'b01, 3'd2, 4'hF, -1, resp);
    check("wrap_prep_bresp", resp, 2'b00);
    do_read(32'h1C, 3, 2'b10, 3'd2, 0, 32'd0);
    check("wrap_b0", rd_data[0], 32'hA3);
    check("wrap_b1", rd_data[1], 32'hA0);
    check("wrap_b2", rd_data[2], 32'hA1);
    check("wrap_b3", rd_data[3], 32'hA2);
    check("wrap_rlast3", rd_last[3], 1'b1);
    check("wrap_rlast2", rd_last[2], 1'b0);

    // RREADY low for 5 cycles holds the first beat
    do_read(32'h10, 1, 2'b01, 3'd2, 5, 32'hA0);
    check("stall_b1", rd_data[1], 32'hA1);
    check("stall_rlast1", rd_last[1], 1'b1);

    // FIXED burst writes one word twice, reads it twice
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    do_write(32'h20, 1, 2'b00, 3'd2, 4'hF, -1, resp);
    check("fixed_bresp", resp, 2'b00);
    do_read(32'h20, 1, 2'b00, 3'd2, 0, 32'd0);
    check("fixed_b0", rd_data[0], 32'h66);
    check("fixed_b1", rd_data[1], 32'h66);

    // Partial strobe merge
    wbuf[0] = 32'h11223344;
    do_write(32'h40, 0, 2'b01, 3'd2, 4'hF, -1, resp);
    wbuf[0] = 32'hAABBCCDD;
    do_write(32'h40, 0, 2'b01, 3'd2, 4'h3, -1, resp);
    check("strb_bresp", resp, 2'b00);
    do_read(32'h40, 0, 2'b01, 3'd2, 0, 32'd0);
    check("strb_merge", rd_data[0], 32'h1122CCDD);
    check("single_rlast", rd_last[0], 1'b1);

    // Reserved burst type: SLVERR and no memory change
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h40, 0, 2'b11, 3'd2, 4'hF, -1, resp);
    check("rsvd_bresp", resp, 2'b10);
    do_read(32'h40, 0, 2'b01, 3'd2, 0, 32'd0);
    check("rsvd_nowrite", rd_data[0], 32'h1122CCDD);

    // Early WLAST on beat 2 of 4
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(i);
    do_write(32'h80, 3, 2'b01, 3'd2, 4'hF, 1, resp);
    check("early_wlast_bresp", resp, 2'b10);

    // Illegal WRAP length: all beats SLVERR with zero data
    do_read(32'h10, 2, 2'b10, 3'd2, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("badwrap_rresp", rd_resp[i], 2'b10);
      check("badwrap_rdata", rd_data[i], 32'd0);
    end
    check("badwrap_rlast", rd_last[2], 1'b1);

    // Non-word size is illegal
    do_read(32'h10, 0, 2'b01, 3'd1, 0, 32'd0);
    check("size_rresp", rd_resp[0], 2'b10);
    check("size_rdata", rd_data[0], 32'd0);

    // INCR crossing 4 KB is rejected; 0xFF8 aliases to word 0x3F8 in a 1 KB memory
    wbuf[0] = 32'h12345678;
    do_write(32'h3F8, 0, 2'b01, 3'd2, 4'hF, -1, resp);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h77;
    do_write(32'hFF8, 3, 2'b01, 3'd2, 4'hF, -1, resp);
    check("4k_bresp", resp, 2'b10);
    do_read(32'hFF8, 0, 2'b01, 3'd2, 0, 32'd0);
    check("4k_nowrite_alias", rd_data[0], 32'h12345678);
    check("alias_rresp", rd_resp[0], 2'b00);

    // Reset pulse in the middle of a read burst
    @(negedge clk);
    araddr = 32'h10; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check("midread_rvalid", rvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", rvalid, 1'b0);
    check("async_rst_arready", arready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_arready", arready, 1'b1);
    check("rerst_awready", awready, 1'b1);
    check("rerst_rvalid", rvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
